// File: rtl/centroid_accumulator_k3_d3.sv
// Streaming k-means centroid accumulator: three centroids by three dimensions.
// Accumulates per-centroid sums and counts, then drains one record per centroid on flush.
module centroid_accumulator_k3_d3 #(
   parameter int input_data_width = 16,
   parameter int acc_width        = 32,
   parameter int count_width      = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [input_data_width-1:0] input_data0,
   input  logic [input_data_width-1:0] input_data1,
   input  logic [input_data_width-1:0] input_data2,
   input  logic [1:0]                  selected_centroid,
   input  logic                        flush,
   output logic                        busy,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [1:0]                  out_centroid,
   output logic [acc_width-1:0]        out_sum0,
   output logic [acc_width-1:0]        out_sum1,
   output logic [acc_width-1:0]        out_sum2,
   output logic [count_width-1:0]      out_count,
   output logic                        done,
   output logic                        dropped
);

   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;

   logic [0:0]             state;
   logic [1:0]             k;
   logic [acc_width-1:0]   sum   [0:2][0:2];
   logic [count_width-1:0] count [0:2];
   logic [acc_width-1:0]   din   [0:2];

   logic in_accum;
   logic accept;
   logic discard;
   logic transfer;
   logic last_transfer;

   always_comb begin
      din[0] = acc_width'(input_data0);
      din[1] = acc_width'(input_data1);
      din[2] = acc_width'(input_data2);
   end

   // Index 3 is never a real centroid, and nothing is taken in while draining.
   assign in_accum      = (state == ACCUM);
   assign accept        = in_accum && in_valid && (selected_centroid != 2'd3);
   assign discard       = in_valid && (!in_accum || (selected_centroid == 2'd3));
   assign transfer      = !in_accum && out_ready;
   assign last_transfer = transfer && (k == 2'd2);

   // A sample arriving with the flush still lands before the drain starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 3; c++) begin
            count[c] <= '0;
            for (int d = 0; d < 3; d++) sum[c][d] <= '0;
         end
      end else if (last_transfer) begin
         for (int c = 0; c < 3; c++) begin
            count[c] <= '0;
            for (int d = 0; d < 3; d++) sum[c][d] <= '0;
         end
      end else if (accept) begin
         for (int c = 0; c < 3; c++) begin
            if (selected_centroid == c[1:0]) begin
               for (int d = 0; d < 3; d++) sum[c][d] <= sum[c][d] + din[d];
               if (count[c] != '1) count[c] <= count[c] + count_width'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
         k     <= 2'd0;
      end else if (in_accum) begin
         if (flush) begin
            state <= DRAIN;
            k     <= 2'd0;
         end
      end else if (transfer) begin
         if (k == 2'd2) begin
            state <= ACCUM;
            k     <= 2'd0;
         end else begin
            k <= k + 2'd1;
         end
      end
   end

   // A discard on the flush edge itself must survive the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done    <= 1'b0;
         dropped <= 1'b0;
      end else begin
         done <= last_transfer;
         if (in_accum && flush) dropped <= discard;
         else if (discard)      dropped <= 1'b1;
      end
   end

   assign busy      = !in_accum;
   assign out_valid = !in_accum;

   always_comb begin
      out_centroid = 2'd0;
      out_sum0     = '0;
      out_sum1     = '0;
      out_sum2     = '0;
      out_count    = '0;
      if (out_valid) begin
         out_centroid = k;
         case (k)
            2'd0: begin
               out_sum0  = sum[0][0];
               out_sum1  = sum[0][1];
               out_sum2  = sum[0][2];
               out_count = count[0];
            end
            2'd1: begin
               out_sum0  = sum[1][0];
               out_sum1  = sum[1][1];
               out_sum2  = sum[1][2];
               out_count = count[1];
            end
            2'd2: begin
               out_sum0  = sum[2][0];
               out_sum1  = sum[2][1];
               out_sum2  = sum[2][2];
               out_count = count[2];
            end
            default: begin
               out_sum0  = '0;
               out_sum1  = '0;
               out_sum2  = '0;
               out_count = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_centroid_accumulator_k3_d3.sv
// Directed bench for centroid_accumulator_k3_d3 with hand-computed records.
module tb_centroid_accumulator_k3_d3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] input_data0, input_data1, input_data2;
   logic [1:0]  selected_centroid;
   logic        flush;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_centroid;
   logic [31:0] out_sum0, out_sum1, out_sum2;
   logic [31:0] out_count;
   logic        done;
   logic        dropped;

   int tests = 0;
   int fails = 0;

   centroid_accumulator_k3_d3 dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .input_data0(input_data0), .input_data1(input_data1), .input_data2(input_data2),
      .selected_centroid(selected_centroid), .flush(flush), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_centroid(out_centroid),
      .out_sum0(out_sum0), .out_sum1(out_sum1), .out_sum2(out_sum2),
      .out_count(out_count), .done(done), .dropped(dropped)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic set_sample(input logic v, input logic [1:0] sel,
                             input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      in_valid          = v;
      selected_centroid = sel;
      input_data0       = a;
      input_data1       = b;
      input_data2       = c;
   endtask

   task automatic send(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      set_sample(1'b1, sel, a, b, c);
      tick();
      set_sample(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   // Checks the record currently presented, then lets it transfer.
   task automatic expect_record(input int kk, input logic [31:0] s0, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [31:0] cnt);
      check($sformatf("k%0d_valid", kk), 64'(out_valid), 64'd1);
      check($sformatf("k%0d_busy", kk), 64'(busy), 64'd1);
      check($sformatf("k%0d_centroid", kk), 64'(out_centroid), 64'(kk));
      check($sformatf("k%0d_sum0", kk), 64'(out_sum0), 64'(s0));
      check($sformatf("k%0d_sum1", kk), 64'(out_sum1), 64'(s1));
      check($sformatf("k%0d_sum2", kk), 64'(out_sum2), 64'(s2));
      check($sformatf("k%0d_count", kk), 64'(out_count), 64'(cnt));
      tick();
   endtask

   task automatic expect_done();
      check("done_pulse", 64'(done), 64'd1);
      check("done_idle_valid", 64'(out_valid), 64'd0);
      check("done_idle_busy", 64'(busy), 64'd0);
      check("done_idle_sum0", 64'(out_sum0), 64'd0);
   endtask

   task automatic drain_zero();
      do_flush();
      expect_record(0, 0, 0, 0, 0);
      expect_record(1, 0, 0, 0, 0);
      expect_record(2, 0, 0, 0, 0);
      expect_done();
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      set_sample(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
      #3;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dropped", 64'(dropped), 64'd0);
      check("rst_count", 64'(out_count), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Basic three-sample accumulation and drain.
      send(2'd0, 16'd1, 16'd2, 16'd3);
      send(2'd0, 16'd4, 16'd5, 16'd6);
      send(2'd2, 16'd10, 16'd10, 16'd10);
      check("accum_not_busy", 64'(busy), 64'd0);
      do_flush();
      expect_record(0, 5, 7, 9, 2);
      expect_record(1, 0, 0, 0, 0);
      expect_record(2, 10, 10, 10, 1);
      expect_done();
      // Sample on the done cycle is accepted.
      send(2'd2, 16'd5, 16'd5, 16'd5);
      check("done_cleared", 64'(done), 64'd0);

      // Sample presented together with flush is included.
      set_sample(1'b1, 2'd1, 16'd7, 16'd7, 16'd7);
      do_flush();
      set_sample(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
      expect_record(0, 0, 0, 0, 0);
      expect_record(1, 7, 7, 7, 1);
      expect_record(2, 5, 5, 5, 1);
      expect_done();
      tick();

      // Back-pressure holds the k0 record; discarded sample and flush in DRAIN.
      send(2'd0, 16'd2, 16'd4, 16'd6);
      out_ready = 1'b0;
      do_flush();
      for (int i = 0; i < 5; i++) begin
         check("hold_centroid", 64'(out_centroid), 64'd0);
         check("hold_sum1", 64'(out_sum1), 64'd4);
         check("hold_count", 64'(out_count), 64'd1);
         if (i == 1) set_sample(1'b1, 2'd1, 16'd9, 16'd9, 16'd9);
         if (i == 2) flush = 1'b1;
         tick();
         set_sample(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
         flush = 1'b0;
      end
      check("hold_dropped", 64'(dropped), 64'd1);
      out_ready = 1'b1;
      expect_record(0, 2, 4, 6, 1);
      expect_record(1, 0, 0, 0, 0);
      expect_record(2, 0, 0, 0, 0);
      expect_done();
      tick();
      check("dropped_sticky", 64'(dropped), 64'd1);

      drain_zero();
      check("flush_clears_dropped", 64'(dropped), 64'd0);

      // Illegal index is discarded; a discard on the flush edge keeps dropped set.
      send(2'd3, 16'd1, 16'd1, 16'd1);
      check("sel3_dropped", 64'(dropped), 64'd1);
      set_sample(1'b1, 2'd3, 16'd2, 16'd2, 16'd2);
      do_flush();
      set_sample(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
      check("flush_discard_keeps_dropped", 64'(dropped), 64'd1);
      expect_record(0, 0, 0, 0, 0);
      expect_record(1, 0, 0, 0, 0);
      expect_record(2, 0, 0, 0, 0);
      expect_done();
      tick();
      drain_zero();
      check("dropped_cleared", 64'(dropped), 64'd0);

      // Reset during the k1 record.
      send(2'd1, 16'd3, 16'd3, 16'd3);
      do_flush();
      expect_record(0, 0, 0, 0, 0);
      check("pre_rst_k1_count", 64'(out_count), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_count", 64'(out_count), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_done", 64'(done), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);
      drain_zero();

      // Full-scale accumulation reaching exactly 2^32-1.
      set_sample(1'b1, 2'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      for (int i = 0; i < 65537; i++) tick();
      set_sample(1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
      do_flush();
      expect_record(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd65537);
      expect_record(1, 0, 0, 0, 0);
      expect_record(2, 0, 0, 0, 0);
      expect_done();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/centroid_accumulator_k3_d3.md
CENTROID_ACCUMULATOR_K3_D3 -- requirements
Module: centroid_accumulator_k3_d3

Interface
REQ-001 Parameter input_data_width, default 16, width of each sample dimension (unsigned).
REQ-002 Parameter acc_width, default 32, width of each per-centroid per-dimension sum.
REQ-003 Parameter count_width, default 32, width of each per-centroid sample count.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 Port in_valid  input  1  current sample/index pair is valid.
REQ-007 Ports input_data0, input_data1, input_data2  input  input_data_width each  sample dimensions 0..2.
REQ-008 Port selected_centroid  input  2  nearest-centroid index for the sample (0..2 legal).
REQ-009 Port flush  input  1  request to drain and clear accumulators.
REQ-010 Port busy  output  1  high while not in ACCUM.
REQ-011 Port out_valid  output  1  drain record valid.
REQ-012 Port out_ready  input  1  consumer accepts the drain record.
REQ-013 Port out_centroid  output  2  centroid index of the record.
REQ-014 Ports out_sum0, out_sum1, out_sum2  output  acc_width each  per-dimension sums.
REQ-015 Port out_count  output  count_width  sample count.
REQ-016 Port done  output  1  one-cycle pulse after the final record transfers.
REQ-017 Port dropped  output  1  sticky: a valid sample was discarded.

Function
REQ-018 States: ACCUM, DRAIN; in DRAIN an internal index k steps 0,1,2.
REQ-019 In ACCUM, in_valid=1 with selected_centroid<=2 adds zero-extended input_dataN to sum[sel][N] and increments count[sel]; the update is visible one cycle later.
REQ-020 Sums wrap modulo 2^acc_width; counts saturate at all-ones.
REQ-021 in_valid=1 with selected_centroid=3 is discarded and sets dropped.
REQ-022 flush=1 in ACCUM moves to DRAIN with k=0 on that edge; a valid sample presented on the same cycle is accumulated first and is included in the drain.
REQ-023 flush in DRAIN is ignored.
REQ-024 In DRAIN, in_valid=1 samples are discarded and set dropped.
REQ-025 In DRAIN, out_valid=1 with out_centroid=k, out_sumN=sum[k][N], out_count=count[k]; outputs stay stable while out_ready=0.
REQ-026 A transfer occurs on a cycle with out_valid=1 and out_ready=1; k then increments.
REQ-027 out_valid first rises the cycle after flush is accepted; with out_ready held high, records k=0,1,2 occupy three consecutive cycles.
REQ-028 On the transfer of k=2, all sums and counts clear to 0 and the state returns to ACCUM.
REQ-029 done=1 for exactly the cycle after the k=2 transfer; samples are accepted again on that same cycle.
REQ-030 dropped clears on the edge that accepts a flush, unless a discard occurs on that same edge, in which case it stays 1.
REQ-031 out_sum*, out_count and out_centroid are 0 whenever out_valid=0.

Reset
REQ-032 rst_n=0 forces ACCUM and k=0 immediately, clears all sums and counts, and drives busy, out_valid, done and dropped to 0; record outputs drive 0.
REQ-033 Reset mid-drain abandons the drain without a done pulse; after release the block is in ACCUM with empty accumulators.

Verification
REQ-034 Samples (1,2,3)->0, (4,5,6)->0, (10,10,10)->2, then flush with out_ready=1 -> records k0 sums (5,7,9) count 2; k1 (0,0,0) count 0; k2 (10,10,10) count 1; done one cycle after k2.
REQ-035 Flush on the same cycle as valid sample (7,7,7)->1 -> k1 record sums (7,7,7) count 1.
REQ-036 out_ready=0 for 5 cycles during the k0 record -> record held stable and k does not advance; dropped=1 if in_valid is pulsed meanwhile.
REQ-037 Samples (65535,65535,65535)->0 repeated 65537 times with acc_width=32 -> sum 0xFFFFFFFF per dimension (no wrap), count 65537.
REQ-038 selected_centroid=3 sample -> no accumulator changes, dropped=1; next flush clears dropped.
REQ-039 rst_n low during the k1 record -> out_valid=0 immediately, no done pulse; a flush after release returns all three records with zero sums and counts.
